config_loader: RTL

//  Fabric configuration front-end feeding the shared config_addr/config_data bus of every PE tile.

---
 rtl/config_loader_pkg.sv | 16 +
 rtl/config_loader_word_shifter.sv | 32 +++
 rtl/config_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/config_loader_pkg.sv
// Shared definitions for the fabric configuration loader: FSM states and record constants.
package config_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_CHK   = 3'd3,
        S_ISSUE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [31:0] TERMINATOR_ADDR = 32'hFFFF_FFFF;
    localparam int unsigned BYTES_PER_WORD  = 4;

endpackage

// File: rtl/config_loader_word_shifter.sv
// config_word_shifter: 4-byte little-endian shift-in register; word_full_o flags the byte that completes a word.
module config_word_shifter
    import config_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    logic [31:0]      word_q;
    logic [IDX_W-1:0] idx_q;

    // Bytes enter at the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (shift_i) begin
            word_q <= {byte_i, word_q[31:8]};
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign word_o      = word_q;
    assign word_full_o = shift_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/config_loader.sv
// config_loader: byte stream to timed {addr,data} config bus writes.
// Optional per-record XOR checksum byte enabled by CONFIG_LOADER_CHECKSUM_EN.
module config_loader
    import config_loader_pkg::*;
#(
    parameter logic [31:0] IDLE_ADDR    = 32'h0,
    parameter int unsigned ISSUE_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [31:0]      config_addr,
    output logic [31:0]      config_data,
    output logic             config_strobe,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] record_count,
    output logic             crc_error
);

    localparam int unsigned IW = $clog2(ISSUE_CYCLES + 1);
    localparam logic [IW-1:0] ISSUE_LAST = IW'(ISSUE_CYCLES - 1);

    state_t           state_q;
    logic [31:0]      addr_q, data_q;
    logic             strobe_q, busy_q, done_q;
    logic [CNT_W-1:0] count_q;
    logic [IW-1:0]    issue_cnt_q;

    logic        accept, addr_full, data_full;
    logic [31:0] addr_word, data_word, addr_next, data_next;
    logic        start_issue, crc_fail;
    logic [31:0] issue_data;

    assign byte_ready = (state_q == S_IDLE) || (state_q == S_ADDR) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
    assign accept     = byte_valid && byte_ready;
    assign addr_next  = {byte_in, addr_word[31:8]};
    assign data_next  = {byte_in, data_word[31:8]};

    config_word_shifter u_addr_shifter (
        .clk_i       (clk),
        .rst_i       (reset),
        .shift_i     (accept && (state_q == S_IDLE || state_q == S_ADDR)),
        .byte_i      (byte_in),
        .word_o      (addr_word),
        .word_full_o (addr_full)
    );

    config_word_shifter u_data_shifter (
        .clk_i       (clk),
        .rst_i       (reset),
        .shift_i     (accept && (state_q == S_DATA)),
        .byte_i      (byte_in),
        .word_o      (data_word),
        .word_full_o (data_full)
    );

`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;
    logic       crc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= '0;
            crc_q <= 1'b0;
        end else begin
            if (accept)
                chk_q <= (state_q == S_IDLE) ? byte_in : (chk_q ^ byte_in);
            if (crc_fail)
                crc_q <= 1'b1;
        end
    end

    always_comb begin
        start_issue = accept && (state_q == S_CHK) && (byte_in == chk_q);
        crc_fail    = accept && (state_q == S_CHK) && (byte_in != chk_q);
        issue_data  = data_word;
    end

    assign crc_error = crc_q;
`else
    always_comb begin
        start_issue = data_full;
        crc_fail    = 1'b0;
        issue_data  = data_next;
    end

    assign crc_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= IDLE_ADDR;
            data_q      <= '0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            issue_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    busy_q  <= 1'b1;
                    state_q <= S_ADDR;
                end
                S_ADDR: if (addr_full) begin
                    if (addr_next == TERMINATOR_ADDR) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
`ifdef CONFIG_LOADER_CHECKSUM_EN
                S_DATA: if (data_full) state_q <= S_CHK;
`endif
                S_CHK: if (crc_fail) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_ISSUE: begin
                    if (issue_cnt_q == ISSUE_LAST) begin
                        state_q  <= S_IDLE;
                        strobe_q <= 1'b0;
                        busy_q   <= 1'b0;
                        addr_q   <= IDLE_ADDR;
                        data_q   <= '0;
                    end else begin
                        issue_cnt_q <= issue_cnt_q + IW'(1);
                    end
                end
                default: ;
            endcase
            // Record entry overrides the per-state transition above.
            if (start_issue) begin
                state_q     <= S_ISSUE;
                addr_q      <= addr_word;
                data_q      <= issue_data;
                strobe_q    <= 1'b1;
                issue_cnt_q <= '0;
                if (count_q != '1)
                    count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign config_addr   = addr_q;
    assign config_data   = data_q;
    assign config_strobe = strobe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign record_count  = count_q;

endmodule
